// File: rtl/fma16_result_queue.sv
// fma16_result_queue
//   Output stage of the fma16 datapath. Rounded 16-bit results and their
//   {NV, OF, UF, NX} flags are buffered in a DEPTH-entry FIFO and released
//   through a valid/ready handshake. Flags of each released entry are
//   OR-accumulated into a sticky fflags register that software can write
//   or selectively clear.
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     in_valid/in_ready     upstream handshake
//     in_result, in_flags   entry written on push
//     out_valid/out_ready   downstream handshake
//     out_result, out_flags head entry (zero when out_valid=0)
//     csr_we, csr_wdata     overwrite fflags
//     csr_clr               per-bit fflags clear mask (ignored when csr_we=1)
//     fflags                sticky accumulated flags
//     occupancy             number of buffered entries
//     retired               count of completed output handshakes (wraps)
module fma16_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [15:0]                in_result,
  input  logic [3:0]                 in_flags,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [15:0]                out_result,
  output logic [3:0]                 out_flags,
  input  logic                       csr_we,
  input  logic [3:0]                 csr_wdata,
  input  logic [3:0]                 csr_clr,
  output logic [3:0]                 fflags,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNTW-1:0]            retired
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0] mem_result [DEPTH];
  logic [3:0]  mem_flags  [DEPTH];

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] occ;

  logic        push;
  logic        pop;
  logic [3:0]  fflags_q;
  logic [3:0]  fflags_next;
  logic [CNTW-1:0] retired_q;

  assign occ       = wptr - rptr;
  assign occupancy = occ;

  // Depends on registered pointers only, so out_ready never reaches in_ready.
  assign in_ready  = (occ != (AW + 1)'(DEPTH));
  assign out_valid = (occ != '0);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Storage is never reset; masking by out_valid hides stale contents.
  assign out_result = out_valid ? mem_result[rptr[AW-1:0]] : '0;
  assign out_flags  = out_valid ? mem_flags[rptr[AW-1:0]]  : '0;

  assign fflags  = fflags_q;
  assign retired = retired_q;

  // Commit is OR-ed after the CSR write/clear so a flag retiring in the
  // same cycle survives the clear.
  always_comb begin
    fflags_next = csr_we ? csr_wdata : (fflags_q & ~csr_clr);
    if (pop) begin
      fflags_next = fflags_next | out_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_result[wptr[AW-1:0]] <= in_result;
      mem_flags[wptr[AW-1:0]]  <= in_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      fflags_q  <= '0;
      retired_q <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + (AW + 1)'(1);
      end
      if (pop) begin
        rptr      <= rptr + (AW + 1)'(1);
        retired_q <= retired_q + CNTW'(1);
      end
      fflags_q <= fflags_next;
    end
  end

endmodule

// File: tb/tb_fma16_result_queue.sv
module tb_fma16_result_queue;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_flags;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic        csr_we;
  logic [3:0]  csr_wdata;
  logic [3:0]  csr_clr;
  logic [3:0]  fflags;
  logic [2:0]  occupancy;
  logic [CNTW-1:0] retired;

  int checks;
  int errors;

  fma16_result_queue #(
    .DEPTH(DEPTH),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .csr_clr   (csr_clr),
    .fflags    (fflags),
    .occupancy (occupancy),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of entries plus sticky flags and a counter.
  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_fflags;
  logic [CNTW-1:0] m_retired;
  bit          live;

  initial begin
    live      = 1'b0;
    m_fflags  = '0;
    m_retired = '0;
  end

  always @(posedge clk) begin
    bit          do_pop;
    bit          do_push;
    ent_t        head;
    ent_t        nw;
    logic [3:0]  base;
    if (reset) begin
      mq.delete();
      m_fflags  = '0;
      m_retired = '0;
      live      = 1'b1;
    end else begin
      do_pop  = (mq.size() > 0) && out_ready;
      do_push = in_valid && (mq.size() < DEPTH);
      base = csr_we ? csr_wdata : (m_fflags & ~csr_clr);
      if (do_pop) begin
        head = mq.pop_front();
        base = base | head.f;
        m_retired = m_retired + 1'b1;
      end
      m_fflags = base;
      if (do_push) begin
        nw.r = in_result;
        nw.f = in_flags;
        mq.push_back(nw);
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic        ev;
    logic [15:0] er;
    logic [3:0]  ef;
    if (live) begin
      ev = (mq.size() != 0);
      er = ev ? mq[0].r : 16'h0;
      ef = ev ? mq[0].f : 4'h0;
      chk("m_out_valid",  32'(out_valid),  32'(ev));
      chk("m_in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
      chk("m_out_result", 32'(out_result), 32'(er));
      chk("m_out_flags",  32'(out_flags),  32'(ef));
      chk("m_fflags",     32'(fflags),     32'(m_fflags));
      chk("m_occupancy",  32'(occupancy),  32'(mq.size()));
      chk("m_retired",    32'(retired),    32'(m_retired));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    out_ready = 1'b0;
    csr_we    = 1'b0;
    csr_wdata = '0;
    csr_clr   = '0;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();

    // Reset then idle
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready",  32'(in_ready),  32'h1);
    chk("rst_occupancy", 32'(occupancy), 32'h0);
    chk("rst_fflags",    32'(fflags),    32'h0);
    chk("rst_retired",   32'(retired),   32'h0);
    chk("rst_out_result", 32'(out_result), 32'h0);

    // Single push with consumer ready
    in_valid  = 1'b1;
    in_result = 16'h3C00;
    in_flags  = 4'b0001;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("one_out_valid",  32'(out_valid),  32'h1);
    chk("one_out_result", 32'(out_result), 32'h3C00);
    chk("one_out_flags",  32'(out_flags),  32'h1);
    chk("one_fflags_pre", 32'(fflags),     32'h0);
    cycle();
    chk("one_fflags",    32'(fflags),    32'h1);
    chk("one_retired",   32'(retired),   32'h1);
    chk("one_occupancy", 32'(occupancy), 32'h0);
    chk("model_fflags_pin",  32'(m_fflags),  32'h1);
    chk("model_retired_pin", 32'(m_retired), 32'h1);

    // Fill with consumer stalled
    out_ready = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      in_valid  = 1'b1;
      in_result = 16'(i);
      in_flags  = 4'b0000;
      cycle();
    end
    chk("full_in_ready",   32'(in_ready),   32'h0);
    chk("full_occupancy",  32'(occupancy),  32'h4);
    chk("full_head",       32'(out_result), 32'h0001);
    in_result = 16'h0005;
    cycle();
    chk("full_reject_occ", 32'(occupancy),  32'h4);
    chk("full_reject_head", 32'(out_result), 32'h0001);

    // Full: push and pop requested together -> pop only
    out_ready = 1'b1;
    cycle();
    chk("fullpop_occ",   32'(occupancy),  32'h3);
    chk("fullpop_head",  32'(out_result), 32'h0002);
    chk("fullpop_ready", 32'(in_ready),   32'h1);
    cycle();
    chk("late_push_occ",  32'(occupancy),  32'h3);
    chk("late_push_head", 32'(out_result), 32'h0003);
    in_valid = 1'b0;
    cycle();
    chk("drain_head4", 32'(out_result), 32'h0004);
    cycle();
    chk("drain_head5", 32'(out_result), 32'h0005);
    cycle();
    chk("drain_empty",   32'(out_valid), 32'h0);
    chk("drain_retired", 32'(retired),   32'h6);

    // fflags CSR interaction
    csr_we    = 1'b1;
    csr_wdata = 4'b1000;
    out_ready = 1'b0;
    cycle();
    csr_we = 1'b0;
    chk("csr_write_1000", 32'(fflags), 32'h8);
    in_valid  = 1'b1;
    in_result = 16'hBEEF;
    in_flags  = 4'b1000;
    cycle();
    in_valid  = 1'b0;
    csr_clr   = 4'b1000;
    out_ready = 1'b1;
    cycle();
    chk("commit_beats_clr", 32'(fflags), 32'h8);
    out_ready = 1'b0;
    cycle();
    chk("clr_no_pop", 32'(fflags), 32'h0);
    csr_clr   = 4'b0000;
    csr_we    = 1'b1;
    csr_wdata = 4'b0110;
    csr_clr   = 4'b1111;
    cycle();
    csr_we  = 1'b0;
    csr_clr = 4'b0000;
    chk("csr_write_0110", 32'(fflags), 32'h6);

    // Queued flags do not reach fflags before commit
    for (int unsigned i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_result = 16'h0A00 + 16'(i);
      in_flags  = 4'b0001;
      cycle();
    end
    in_valid = 1'b0;
    chk("queued_no_flags", 32'(fflags),    32'h6);
    chk("queued_occ",      32'(occupancy), 32'h3);

    // Reset mid-operation with consumer ready: nothing retires
    reset     = 1'b1;
    out_ready = 1'b1;
    cycle();
    reset = 1'b0;
    out_ready = 1'b0;
    chk("mid_rst_occ",     32'(occupancy), 32'h0);
    chk("mid_rst_valid",   32'(out_valid), 32'h0);
    chk("mid_rst_fflags",  32'(fflags),    32'h0);
    chk("mid_rst_retired", 32'(retired),   32'h0);
    cycle();

    // Streaming push/pop across pointer wrap
    out_ready = 1'b1;
    for (int unsigned k = 0; k <= 2 * DEPTH; k++) begin
      in_valid  = 1'b1;
      in_result = 16'h0100 + 16'(k);
      in_flags  = 4'(k);
      cycle();
      chk("wrap_head", 32'(out_result), 32'h0100 + k);
      chk("wrap_occ",  32'(occupancy),  32'h1);
    end
    in_valid = 1'b0;
    cycle();
    chk("wrap_empty",   32'(out_valid), 32'h0);
    chk("wrap_retired", 32'(retired),   32'h9);
    chk("wrap_fflags",  32'(fflags),    32'hF);
    out_ready = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fma16_result_queue.md
Name: fma16_result_queue

Overview:
Downstream stage of the fma16 datapath. It consumes each rounded 16-bit result and its {invalid, overflow, underflow, inexact} flags, and buffers them in a small FIFO. Results are released to the consumer with a valid/ready handshake. Committed flags are OR-accumulated into a sticky, software-visible fflags register (RISC-V fcsr style), with write and clear controls.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CNTW, 16, width of the retired-result counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  upstream result/flags valid.
in_ready  out  1  queue can accept an entry this cycle.
in_result  in  16  rounded half-precision result.
in_flags  in  4  {NV, OF, UF, NX} for in_result.
out_valid  out  1  head entry available.
out_ready  in  1  consumer accepts the head entry.
out_result  out  16  head entry result.
out_flags  out  4  head entry flags.
csr_we  in  1  overwrite fflags with csr_wdata.
csr_wdata  in  4  value written to fflags.
csr_clr  in  4  per-bit clear mask for fflags; ignored when csr_we=1.
fflags  out  4  sticky accumulated flags {NV, OF, UF, NX}.
occupancy  out  $clog2(DEPTH)+1  number of valid entries.
retired  out  CNTW  count of completed output handshakes.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. With reset high at a rising edge, the following are cleared that cycle: read/write pointers, occupancy, fflags, retired, and all storage valid state.
- Outputs after reset: out_valid=0, in_ready=1, out_result=0, out_flags=0, fflags=0, occupancy=0, retired=0.
- Reset asserted mid-operation discards all buffered entries. No handshake completes on a reset cycle.
- Push: occurs when in_valid & in_ready. The entry is written at wptr and wptr increments, wrapping modulo DEPTH.
- Pop: occurs when out_valid & out_ready. rptr increments, wrapping modulo DEPTH.
- in_ready = (occupancy != DEPTH); it is combinational from registered state only, with no dependency on out_ready.
  - When the queue is full, a same-cycle pop does not allow a push.
  - No combinational path exists from out_ready to in_ready.
- out_valid = (occupancy != 0).
- out_result and out_flags present the head entry directly from storage. They hold stable while out_valid=1 and out_ready=0.
- When out_valid=0, out_result and out_flags are 0 (masked).
- Latency: an entry pushed in cycle N is visible on the outputs in cycle N+1. There is no empty-bypass.
- Occupancy update: push only → +1; pop only → −1; push and pop together (not full, not empty) → unchanged.
- Pointers use a log2(DEPTH)+1-bit form so full and empty are distinguished. occupancy = wptr − rptr.
- fflags next-state:
  - base = csr_we ? csr_wdata : (fflags & ~csr_clr)
  - fflags_next = base | (pop ? out_flags : 4'b0)
  - A flag committed in the same cycle as a CSR write or clear is never lost. Commit takes priority over clear.
- Flags accumulate at pop (the commit point), not at push. Entries still queued do not affect fflags.
- retired increments by 1 on every pop and wraps from 2^CNTW−1 to 0.
- No storage or flag reset is required beyond the clearing above. Stale storage data is never visible because the outputs are masked by out_valid.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, occupancy=0, fflags=4'b0000, retired=0.
- Push 16'h3C00 with flags 4'b0001, out_ready=1 → out_valid rises next cycle with out_result=16'h3C00. After the pop: fflags=4'b0001, retired=1, occupancy=0.
- With out_ready=0, push 4 entries (DEPTH=4) → in_ready=0, occupancy=4. A 5th in_valid is not accepted. Asserting out_ready pops the entries in order: 16'h0001, 16'h0002, 16'h0003, 16'h0004.
- Full queue, in_valid=1 and out_ready=1 in the same cycle → pop only, occupancy 4→3. The push is accepted the following cycle.
- fflags=4'b1000; same cycle: csr_clr=4'b1000 and a pop with flags 4'b1000 → fflags stays 4'b1000. Next cycle csr_clr=4'b1000 with no pop → fflags=4'b0000. csr_we=1 with csr_wdata=4'b0110 → fflags=4'b0110.
- Three entries queued, reset asserted for one cycle → occupancy=0, out_valid=0, fflags=0, retired=0. The pointers wrap correctly after 2×DEPTH subsequent push/pop pairs.
